// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I processor with machine-mode CSRs and trap
// handling, plus a 64 KiB unified instruction/data memory.
//
// Ports:
//   clk - single clock; pc, register file, CSRs and memory update on its
//         rising edge (one instruction retires per edge).
//   rst - asynchronous active-low reset; clears pc, rs[] and csr[], but
//         leaves memory contents intact so a preloaded image survives.
//
// Externally visible state (hierarchical): pc, rs[0..31], csr[0..4095],
// memory.m[].

// rv32_mem: byte array with one combinational fetch port, one combinational
// data-read port and one byte-strobed write port. All accesses are performed
// byte-wise so misaligned words work. Addresses wrap modulo MEM_BYTES, which
// must be a power of two.
module rv32_mem #(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    output logic [31:0] rdata,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0] m [0:MEM_BYTES-1];

    function automatic logic [AW-1:0] wrap(input logic [31:0] a, input logic [31:0] off);
        return AW'(a + off);
    endfunction

    // Little-endian: byte at the lowest address lands in bits [7:0].
    assign idata = {m[wrap(iaddr, 32'd3)], m[wrap(iaddr, 32'd2)],
                    m[wrap(iaddr, 32'd1)], m[wrap(iaddr, 32'd0)]};
    assign rdata = {m[wrap(daddr, 32'd3)], m[wrap(daddr, 32'd2)],
                    m[wrap(daddr, 32'd1)], m[wrap(daddr, 32'd0)]};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) m[wrap(daddr, 32'(i))] <= wdata[8*i +: 8];
        end
    end
endmodule

module rv32_core #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic [31:0] instr, mem_rdata, mem_wdata, daddr;
    logic [3:0]  wstrb, mem_wstrb;

    // Stores are suppressed while reset is asserted so a preload done during
    // reset cannot be corrupted by whatever word sits at the reset pc.
    assign mem_wstrb = rst ? wstrb : 4'b0000;

    rv32_mem #(.MEM_BYTES(MEM_BYTES)) memory (
        .clk   (clk),
        .iaddr (pc),
        .idata (instr),
        .daddr (daddr),
        .rdata (mem_rdata),
        .wstrb (mem_wstrb),
        .wdata (mem_wdata)
    );

    // Decode fields and immediates.
    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rv1, rv2, pc_plus4;
    logic [31:0] jal_t, jalr_t, br_t;
    logic [31:0] csr_old, mstatus, mtvec, mepc;

    assign opcode   = instr[6:0];
    assign rd_idx   = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1_idx  = instr[19:15];
    assign rs2_idx  = instr[24:20];
    assign csr_addr = instr[31:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rv1 = (rs1_idx == 5'd0) ? 32'd0 : rs[rs1_idx];
    assign rv2 = (rs2_idx == 5'd0) ? 32'd0 : rs[rs2_idx];

    assign pc_plus4 = pc + 32'd4;
    assign jal_t    = pc + imm_j;
    assign jalr_t   = (rv1 + imm_i) & ~32'h1;
    assign br_t     = pc + imm_b;

    assign csr_old = csr[csr_addr];
    assign mstatus = csr[CSR_MSTATUS];
    assign mtvec   = csr[CSR_MTVEC];
    assign mepc    = csr[CSR_MEPC];

    function automatic logic [31:0] alu(input logic [2:0] fn, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
        case (fn)
            3'b000:  return alt ? (a - b) : (a + b);
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] fn, input logic [31:0] a,
                                      input logic [31:0] b);
        case (fn)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    logic [31:0] next_pc, rd_val, csr_wval, csr_src, cause, tval;
    logic        rd_we, csr_we, trap, mret;

    always_comb begin
        next_pc   = pc_plus4;
        rd_we     = 1'b0;
        rd_val    = 32'd0;
        wstrb     = 4'b0000;
        daddr     = 32'd0;
        mem_wdata = rv2;
        csr_we    = 1'b0;
        csr_wval  = 32'd0;
        csr_src   = f3[2] ? {27'b0, rs1_idx} : rv1;
        trap      = 1'b0;
        cause     = 32'd0;
        tval      = 32'd0;
        mret      = 1'b0;

        case (opcode)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OP_JAL: begin
                if (jal_t[1]) begin
                    trap = 1'b1;
                    tval = jal_t;
                end else begin
                    rd_we   = 1'b1;
                    rd_val  = pc_plus4;
                    next_pc = jal_t;
                end
            end
            OP_JALR: begin
                if (jalr_t[1]) begin
                    trap = 1'b1;
                    tval = jalr_t;
                end else begin
                    rd_we   = 1'b1;
                    rd_val  = pc_plus4;
                    next_pc = jalr_t;
                end
            end
            OP_BRANCH: begin
                // A not-taken branch never traps, whatever its target.
                if (br_taken(f3, rv1, rv2)) begin
                    if (br_t[1]) begin
                        trap = 1'b1;
                        tval = br_t;
                    end else begin
                        next_pc = br_t;
                    end
                end
            end
            OP_LOAD: begin
                daddr = rv1 + imm_i;
                rd_we = 1'b1;
                case (f3)
                    3'b000:  rd_val = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
                    3'b001:  rd_val = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
                    3'b100:  rd_val = {24'b0, mem_rdata[7:0]};
                    3'b101:  rd_val = {16'b0, mem_rdata[15:0]};
                    default: rd_val = mem_rdata;
                endcase
            end
            OP_STORE: begin
                daddr = rv1 + imm_s;
                case (f3)
                    3'b000:  wstrb = 4'b0001;
                    3'b001:  wstrb = 4'b0011;
                    default: wstrb = 4'b1111;
                endcase
            end
            OP_IMM: begin
                rd_we  = 1'b1;
                // Only SRAI uses bit 30 as a modifier; ADDI with a negative
                // immediate must not turn into a subtract.
                rd_val = alu(f3, rv1, imm_i, (f3 == 3'b101) && instr[30]);
            end
            OP_REG: begin
                rd_we  = 1'b1;
                rd_val = alu(f3, rv1, rv2, instr[30]);
            end
            OP_FENCE: begin
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    case (csr_addr)
                        12'h000: begin
                            trap  = 1'b1;
                            cause = 32'd11;
                        end
                        12'h001: begin
                            trap  = 1'b1;
                            cause = 32'd3;
                            tval  = pc;
                        end
                        12'h302: begin
                            mret    = 1'b1;
                            next_pc = mepc;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    // Set/clear forms with a zero source register field (or
                    // zero immediate) are pure reads.
                    case (f3[1:0])
                        2'b01: begin
                            csr_we   = 1'b1;
                            csr_wval = csr_src;
                        end
                        2'b10: begin
                            csr_we   = (rs1_idx != 5'd0);
                            csr_wval = csr_old | csr_src;
                        end
                        2'b11: begin
                            csr_we   = (rs1_idx != 5'd0);
                            csr_wval = csr_old & ~csr_src;
                        end
                        default: rd_we = 1'b0;
                    endcase
                end
            end
            default: begin
                trap  = 1'b1;
                cause = 32'd2;
                tval  = instr;
            end
        endcase

        // A trapping instruction has no architectural side effects other
        // than the trap CSRs and the redirect.
        if (trap) begin
            next_pc = mtvec & ~32'h3;
            rd_we   = 1'b0;
            wstrb   = 4'b0000;
            csr_we  = 1'b0;
        end
    end

    // mstatus: MIE = bit 3, MPIE = bit 7, MPP = bits 12:11.
    logic [31:0] mstatus_trap, mstatus_mret;
    always_comb begin
        mstatus_trap        = mstatus;
        mstatus_trap[7]     = mstatus[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = mstatus;
        mstatus_mret[3]     = mstatus[7];
        mstatus_mret[7]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
            for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (rd_we && (rd_idx != 5'd0)) rs[rd_idx] <= rd_val;
            if (trap) begin
                csr[CSR_MEPC]    <= pc;
                csr[CSR_MCAUSE]  <= cause;
                csr[CSR_MTVAL]   <= tval;
                csr[CSR_MSTATUS] <= mstatus_trap;
            end else if (mret) begin
                csr[CSR_MSTATUS] <= mstatus_mret;
            end else if (csr_we) begin
                csr[csr_addr] <= csr_wval;
            end
        end
    end
endmodule

// File: tb/tb_rv32_core.sv
// Testbench for rv32_core: a table of single-instruction vectors (address,
// encoded instruction, register to inspect, expected value, expected pc)
// stepped one clock at a time, followed by a hand-written trap/CSR sequence.
module tb_rv32_core;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_core dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          chk_reg;   // -1: only the pc is checked
        logic [31:0] exp_val;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    // Instruction encoders.
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        for (int i = 0; i < 4; i++) dut.memory.m[16'(addr + 32'(i))] = word[8*i +: 8];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) dut.memory.m[i] = 8'h00;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        vecs[0]  = '{32'h00, enc_i(32'd5, 0, 3'b000, 1, 7'h13),        1,  32'h0000_0005, 32'h04};
        vecs[1]  = '{32'h04, enc_i(-32'sd7, 1, 3'b000, 2, 7'h13),      2,  32'hFFFF_FFFE, 32'h08};
        vecs[2]  = '{32'h08, enc_r(7'h00, 1, 2, 3'b011, 3),            3,  32'h0000_0000, 32'h0C};
        vecs[3]  = '{32'h0C, enc_u(32'h80000, 10, 7'h37),              10, 32'h8000_0000, 32'h10};
        vecs[4]  = '{32'h10, enc_i(32'hFF, 10, 3'b000, 10, 7'h13),     10, 32'h8000_00FF, 32'h14};
        vecs[5]  = '{32'h14, enc_s(32'h100, 10, 0, 3'b010),            -1, 32'h0,         32'h18};
        vecs[6]  = '{32'h18, enc_i(32'h100, 0, 3'b000, 4, 7'h03),      4,  32'hFFFF_FFFF, 32'h1C};
        vecs[7]  = '{32'h1C, enc_i(32'h102, 0, 3'b101, 5, 7'h03),      5,  32'h0000_8000, 32'h20};
        vecs[8]  = '{32'h20, enc_r(7'h20, 2, 1, 3'b000, 11),           11, 32'h0000_0007, 32'h24};
        vecs[9]  = '{32'h24, enc_i(32'h404, 10, 3'b101, 12, 7'h13),    12, 32'hF800_000F, 32'h28};
        vecs[10] = '{32'h28, enc_i(32'd31, 10, 3'b101, 13, 7'h13),     13, 32'h0000_0001, 32'h2C};
        vecs[11] = '{32'h2C, enc_r(7'h00, 1, 2, 3'b010, 14),           14, 32'h0000_0001, 32'h30};
        vecs[12] = '{32'h30, enc_i(32'hFFF, 1, 3'b100, 15, 7'h13),     15, 32'hFFFF_FFFA, 32'h34};
        vecs[13] = '{32'h34, enc_u(32'h1, 16, 7'h17),                  16, 32'h0000_1034, 32'h38};
        vecs[14] = '{32'h38, enc_r(7'h00, 1, 1, 3'b001, 17),           17, 32'h0000_00A0, 32'h3C};
        vecs[15] = '{32'h3C, enc_b(32'd8, 1, 1, 3'b000),               -1, 32'h0,         32'h44};
        vecs[16] = '{32'h44, enc_b(32'd8, 1, 1, 3'b001),               -1, 32'h0,         32'h48};
        vecs[17] = '{32'h48, enc_j(32'd8, 18),                         18, 32'h0000_004C, 32'h50};
        vecs[18] = '{32'h50, enc_i(32'd5, 0, 3'b000, 0, 7'h13),        0,  32'h0000_0000, 32'h54};
        vecs[19] = '{32'h54, enc_i(32'h102, 0, 3'b001, 20, 7'h03),     20, 32'hFFFF_8000, 32'h58};
        vecs[20] = '{32'h58, enc_i(32'h100, 0, 3'b010, 21, 7'h03),     21, 32'h8000_00FF, 32'h5C};
        vecs[21] = '{32'h5C, enc_s(32'h101, 1, 0, 3'b001),             -1, 32'h0,         32'h60};
        vecs[22] = '{32'h60, enc_i(32'h100, 0, 3'b010, 22, 7'h03),     22, 32'h8000_05FF, 32'h64};
        vecs[23] = '{32'h64, enc_i(32'h0FF, 0, 3'b010, 23, 7'h03),     23, 32'h0005_FF00, 32'h68};
        vecs[24] = '{32'h68, enc_b(32'd8, 1, 2, 3'b110),               -1, 32'h0,         32'h6C};
        vecs[25] = '{32'h6C, enc_b(32'd8, 2, 1, 3'b101),               -1, 32'h0,         32'h74};
        vecs[26] = '{32'h74, enc_r(7'h20, 1, 2, 3'b101, 24),           24, 32'hFFFF_FFFF, 32'h78};
        vecs[27] = '{32'h78, enc_i(32'h0F0, 10, 3'b111, 25, 7'h13),    25, 32'h0000_00F0, 32'h7C};

        // Reset: a negedge on rst from a released state.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        clear_mem();
        for (int i = 0; i < NV; i++) put(vecs[i].addr, vecs[i].instr);
        step(2);
        check("reset_pc", dut.pc, 32'h0);
        check("reset_rs3", dut.rs[3], 32'h0);
        check("reset_mepc", dut.csr[12'h341], 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("first_fetch_pc", dut.pc, 32'h0);

        for (int i = 0; i < NV; i++) begin
            step(1);
            if (vecs[i].chk_reg >= 0)
                check($sformatf("vec%0d_rs%0d", i, vecs[i].chk_reg),
                      dut.rs[vecs[i].chk_reg], vecs[i].exp_val);
            check($sformatf("vec%0d_pc", i), dut.pc, vecs[i].exp_pc);
        end
        check("mem_0x101_after_sh", {24'b0, dut.memory.m[16'h101]}, 32'h05);

        // Second reset clears registers written above; memory is reloaded.
        do_reset();
        check("reset2_rs1", dut.rs[1], 32'h0);
        check("reset2_pc", dut.pc, 32'h0);
        clear_mem();
        put(32'h00, enc_i(32'h200, 0, 3'b000, 1, 7'h13));        // addi x1,x0,0x200
        put(32'h04, enc_i(32'h305, 1, 3'b001, 0, 7'h73));        // csrrw x0,mtvec,x1
        put(32'h08, enc_i(32'h55, 0, 3'b000, 6, 7'h13));         // addi x6,x0,0x55
        put(32'h0C, enc_i(32'h300, 8, 3'b101, 0, 7'h73));        // csrrwi x0,mstatus,8
        put(32'h10, enc_j(32'h10, 0));                           // jal x0,+0x10
        put(32'h20, enc_i(32'h102, 0, 3'b000, 6, 7'h67));        // jalr x6,0x102(x0)
        put(32'h200, 32'h3020_0073);                             // mret
        @(negedge clk);
        rst = 1'b1;

        step(5);
        check("setup_pc", dut.pc, 32'h20);
        check("setup_mtvec", dut.csr[12'h305], 32'h200);
        check("setup_mstatus", dut.csr[12'h300], 32'h8);

        step(1);
        check("mis_pc", dut.pc, 32'h200);
        check("mis_mepc", dut.csr[12'h341], 32'h20);
        check("mis_mcause", dut.csr[12'h342], 32'h0);
        check("mis_mtval", dut.csr[12'h343], 32'h102);
        check("mis_rs6", dut.rs[6], 32'h55);
        check("mis_mstatus", dut.csr[12'h300], 32'h1880);

        step(1);
        check("mret_pc", dut.pc, 32'h20);
        check("mret_mstatus", dut.csr[12'h300], 32'h1888);

        put(32'h20, enc_i(32'h341, 5'h10, 3'b101, 7, 7'h73));   // csrrwi x7,mepc,0x10
        put(32'h24, enc_i(32'h300, 0, 3'b000, 1, 7'h13));        // addi x1,x0,0x300
        put(32'h28, enc_i(32'h305, 1, 3'b001, 0, 7'h73));        // csrrw x0,mtvec,x1
        put(32'h2C, enc_j(32'h14, 0));                           // jal x0,+0x14
        put(32'h40, 32'h0000_0073);                              // ecall
        put(32'h300, 32'hFFFF_FFFF);                             // illegal opcode
        step(1);
        check("csrrwi_rs7", dut.rs[7], 32'h20);
        check("csrrwi_mepc", dut.csr[12'h341], 32'h10);

        step(3);
        check("pre_ecall_pc", dut.pc, 32'h40);
        step(1);
        check("ecall_pc", dut.pc, 32'h300);
        check("ecall_mcause", dut.csr[12'h342], 32'd11);
        check("ecall_mepc", dut.csr[12'h341], 32'h40);
        check("ecall_mtval", dut.csr[12'h343], 32'h0);
        check("ecall_mstatus", dut.csr[12'h300], 32'h1880);

        step(1);
        check("illegal_pc", dut.pc, 32'h300);
        check("illegal_mcause", dut.csr[12'h342], 32'd2);
        check("illegal_mtval", dut.csr[12'h343], 32'hFFFF_FFFF);
        check("illegal_mepc", dut.csr[12'h341], 32'h300);
        check("illegal_mstatus", dut.csr[12'h300], 32'h1800);

        put(32'h300, 32'h0010_0073);                             // ebreak
        step(1);
        check("ebreak_mcause", dut.csr[12'h342], 32'd3);
        check("ebreak_mtval", dut.csr[12'h343], 32'h300);
        check("ebreak_pc", dut.pc, 32'h300);

        put(32'h300, enc_b(32'd6, 0, 0, 3'b000));                // beq x0,x0,+6
        step(1);
        check("br_mis_mcause", dut.csr[12'h342], 32'd0);
        check("br_mis_mtval", dut.csr[12'h343], 32'h306);
        check("br_mis_pc", dut.pc, 32'h300);

        put(32'h300, enc_b(32'd6, 0, 0, 3'b001));                // bne x0,x0,+6
        step(1);
        check("br_nt_pc", dut.pc, 32'h304);
        check("br_nt_mtval", dut.csr[12'h343], 32'h306);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
